// File: rtl/addsub_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_arb_pkg
//  Description : Shared types for the add/sub arbiter: FSM states and tag format.
//  Revision    : 1.0 - initial release
// ============================================================================
package addsub_arb_pkg;

   localparam int DATA_W   = 64;
   localparam int TAG_ID_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   typedef struct packed {
      logic                vld;
      logic [TAG_ID_W-1:0] id;
   } tag_t;

endpackage
`default_nettype wire

// File: rtl/addsub_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin pick: first request at or after ptr.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
   import addsub_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
)(
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [ID_W-1:0]  gnt_id,
   output logic             gnt_vld
);

   logic [ID_W-1:0] w_idx;

   always_comb begin
      gnt     = '0;
      gnt_id  = '0;
      gnt_vld = 1'b0;
      w_idx   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         w_idx = ID_W'((int'(ptr) + k) % N_REQ);
         if (!gnt_vld && req[w_idx]) begin
            gnt_vld    = 1'b1;
            gnt[w_idx] = 1'b1;
            gnt_id     = w_idx;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/addsub_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_arbiter
//  Description : Round-robin share of one 64-bit add/sub unit with tagged
//                broadcast responses and flush/park. Optional statistics
//                counters enabled by defining ADDSUB_ARB_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module addsub_arbiter
   import addsub_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2,
   parameter int LAT   = 1
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [DATA_W*N_REQ-1:0] req_a,
   input  logic [DATA_W*N_REQ-1:0] req_b,
   input  logic [N_REQ-1:0]        req_mode,
   output logic [N_REQ-1:0]        req_ready,
   input  logic                    flush,
   output logic                    flush_done,
   output logic [DATA_W-1:0]       op_a,
   output logic [DATA_W-1:0]       op_b,
   output logic                    op_mode,
   input  logic [DATA_W-1:0]       res_sum,
   input  logic                    res_carry,
   output logic                    rsp_valid,
   output logic [ID_W-1:0]         rsp_id,
   output logic [DATA_W-1:0]       rsp_sum,
`ifdef ADDSUB_ARB_STATS_EN
   output logic [31:0]             issue_cnt,
   output logic [31:0]             busy_cnt,
`endif
   output logic                    rsp_carry
);

   generate
      if (ID_W != $clog2(N_REQ) || N_REQ < 2 || N_REQ > 8 || LAT < 1 || LAT > 4) begin : g_param_chk
         $error("addsub_arbiter: unsupported N_REQ/ID_W/LAT combination");
      end
   endgenerate

   state_t          r_state;
   logic [ID_W-1:0] r_rr_ptr;
   logic [LAT-1:0]  r_tag_vld;
   logic [ID_W-1:0] r_tag_id [LAT];

   logic [N_REQ-1:0] w_gnt;
   logic [ID_W-1:0]  w_gnt_id;
   logic             w_gnt_any;
   logic             w_grant_en;
   logic             w_issue;
   logic             w_pipe_busy;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_rr (
      .req     (req_valid),
      .ptr     (r_rr_ptr),
      .gnt     (w_gnt),
      .gnt_id  (w_gnt_id),
      .gnt_vld (w_gnt_any)
   );

   // flush in RUN suppresses the grant in the same cycle
   assign w_grant_en  = (r_state == ST_RUN) && !flush;
   assign w_issue     = w_grant_en && w_gnt_any;
   assign w_pipe_busy = |r_tag_vld;
   assign req_ready   = w_grant_en ? w_gnt : '0;

   always_comb begin
      op_a    = '0;
      op_b    = '0;
      op_mode = 1'b0;
      if (w_issue) begin
         op_a    = req_a[DATA_W*w_gnt_id +: DATA_W];
         op_b    = req_b[DATA_W*w_gnt_id +: DATA_W];
         op_mode = req_mode[w_gnt_id];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         flush_done <= 1'b0;
      end else begin
         flush_done <= 1'b0;
         case (r_state)
            ST_IDLE:  if (!flush) r_state <= ST_RUN;
            ST_RUN:   if (flush)  r_state <= ST_DRAIN;
            ST_DRAIN: begin
               if (!w_pipe_busy) begin
                  r_state    <= ST_IDLE;
                  flush_done <= 1'b1;
               end
            end
            default:  r_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr_ptr <= '0;
      end else if (w_issue) begin
         r_rr_ptr <= (w_gnt_id == ID_W'(N_REQ-1)) ? '0 : w_gnt_id + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tag_vld <= '0;
         for (int s = 0; s < LAT; s++) r_tag_id[s] <= '0;
      end else begin
         r_tag_vld[0] <= w_issue;
         r_tag_id[0]  <= w_gnt_id;
         for (int s = 1; s < LAT; s++) begin
            r_tag_vld[s] <= r_tag_vld[s-1];
            r_tag_id[s]  <= r_tag_id[s-1];
         end
      end
   end

   // last tag stage lines up with the adder result of the same op
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_sum   <= '0;
         rsp_carry <= 1'b0;
      end else begin
         rsp_valid <= r_tag_vld[LAT-1];
         if (r_tag_vld[LAT-1]) begin
            rsp_id    <= r_tag_id[LAT-1];
            rsp_sum   <= res_sum;
            rsp_carry <= res_carry;
         end
      end
   end

`ifdef ADDSUB_ARB_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issue_cnt <= '0;
         busy_cnt  <= '0;
      end else if (r_state != ST_IDLE) begin
         if (w_issue)     issue_cnt <= issue_cnt + 32'd1;
         if (w_pipe_busy) busy_cnt  <= busy_cnt + 32'd1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_addsub_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_addsub_arbiter
//  Description : Directed scoreboard bench for addsub_arbiter with an adder model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_addsub_arbiter;

   localparam int N = 4;

   logic          clk;
   logic          rst_n;
   logic [N-1:0]  req_valid;
   logic [64*N-1:0] req_a;
   logic [64*N-1:0] req_b;
   logic [N-1:0]  req_mode;
   logic [N-1:0]  req_ready;
   logic          flush;
   logic          flush_done;
   logic [63:0]   op_a, op_b;
   logic          op_mode;
   logic [63:0]   res_sum;
   logic          res_carry;
   logic          rsp_valid;
   logic [1:0]    rsp_id;
   logic [63:0]   rsp_sum;
   logic          rsp_carry;
`ifdef ADDSUB_ARB_STATS_EN
   logic [31:0]   issue_cnt, busy_cnt;
`endif

   addsub_arbiter #(.N_REQ(N), .ID_W(2), .LAT(1)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_mode   (req_mode),
      .req_ready  (req_ready),
      .flush      (flush),
      .flush_done (flush_done),
      .op_a       (op_a),
      .op_b       (op_b),
      .op_mode    (op_mode),
      .res_sum    (res_sum),
      .res_carry  (res_carry),
      .rsp_valid  (rsp_valid),
      .rsp_id     (rsp_id),
      .rsp_sum    (rsp_sum),
`ifdef ADDSUB_ARB_STATS_EN
      .issue_cnt  (issue_cnt),
      .busy_cnt   (busy_cnt),
`endif
      .rsp_carry  (rsp_carry)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // one-cycle adder; carry bit set on borrow when subtracting
   always @(posedge clk) begin
      {res_carry, res_sum} <= op_mode ? ({1'b0, op_a} - {1'b0, op_b})
                                      : ({1'b0, op_a} + {1'b0, op_b});
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          id;
      logic [63:0] sum;
      logic        carry;
      int          cyc;
   } exp_t;

   exp_t        q[$];
   exp_t        e;
   logic [63:0] es [N];
   logic        ec [N];
   int          n_cmp = 0;
   int          n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic set_slice(input int i, input logic [63:0] a, input logic [63:0] b,
                            input logic m, input logic [63:0] s, input logic c);
      req_a[64*i +: 64] = a;
      req_b[64*i +: 64] = b;
      req_mode[i]       = m;
      es[i]             = s;
      ec[i]             = c;
   endtask

   // drive one cycle of requests, check the grant, queue the response if expected
   task automatic cyc_check(input logic [N-1:0] vld, input logic [N-1:0] exp_rdy, input bit push);
      int id;
      @(posedge clk); #1;
      req_valid = vld;
      #1;
      chk("req_ready", req_ready, exp_rdy);
      if (push) begin
         id = 0;
         for (int i = 0; i < N; i++) if (exp_rdy[i]) id = i;
         chk("op_a", op_a, req_a[64*id +: 64]);
         chk("op_b", op_b, req_b[64*id +: 64]);
         chk("op_mode", op_mode, req_mode[id]);
         q.push_back('{id, es[id], ec[id], cyc + 2});
      end
   endtask

   always @(negedge clk) begin
      if (rsp_valid) begin
         if (q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_rsp: got id %0d sum %0h, expected none (cycle %0d)", rsp_id, rsp_sum, cyc);
         end else begin
            e = q.pop_front();
            chk("rsp_id", rsp_id, e.id);
            chk("rsp_sum", rsp_sum, e.sum);
            chk("rsp_carry", rsp_carry, e.carry);
            chk("rsp_cycle", cyc, e.cyc);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; flush = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_mode = '0;
      for (int i = 0; i < N; i++) begin es[i] = '0; ec[i] = 1'b0; end
      set_slice(0, 64'h5, 64'h5, 1'b0, 64'ha, 1'b0);
      req_valid = 4'b1111;
      flush = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_req_ready", req_ready, 4'b0000);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rsp_id", rsp_id, 2'd0);
      chk("rst_rsp_sum", rsp_sum, 64'd0);
      chk("rst_rsp_carry", rsp_carry, 1'b0);
      chk("rst_flush_done", flush_done, 1'b0);
      chk("rst_op_a", op_a, 64'd0);
      chk("rst_op_b", op_b, 64'd0);
      chk("rst_op_mode", op_mode, 1'b0);
      req_valid = '0;
      @(posedge clk); #3;
      rst_n = 1'b1;
      cyc_check(4'b0000, 4'b0000, 0);
      cyc_check(4'b0000, 4'b0000, 0);

      // single add, then subtract with borrow, then carry-out add
      set_slice(1, 64'hfff, 64'hffff, 1'b0, 64'h10ffe, 1'b0);
      cyc_check(4'b0010, 4'b0010, 1);
      cyc_check(4'b0000, 4'b0000, 0);
      set_slice(2, 64'd5, 64'd7, 1'b1, 64'hffff_ffff_ffff_fffe, 1'b1);
      cyc_check(4'b0100, 4'b0100, 1);
      cyc_check(4'b0000, 4'b0000, 0);
      set_slice(3, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'd0, 1'b1);
      cyc_check(4'b1000, 4'b1000, 1);
      cyc_check(4'b0000, 4'b0000, 0);

      // all four valid with pointer back at 0: strict rotation
      set_slice(0, 64'h100, 64'd1, 1'b0, 64'h101, 1'b0);
      set_slice(1, 64'h200, 64'd2, 1'b1, 64'h1fe, 1'b0);
      set_slice(2, 64'h300, 64'd3, 1'b0, 64'h303, 1'b0);
      set_slice(3, 64'h400, 64'd4, 1'b1, 64'h3fc, 1'b0);
      for (int k = 0; k < 8; k++) cyc_check(4'b1111, 4'b0001 << (k % 4), 1);
      cyc_check(4'b0000, 4'b0000, 0);

      // flush with one op in flight
      set_slice(0, 64'd1, 64'd2, 1'b0, 64'd3, 1'b0);
      cyc_check(4'b0001, 4'b0001, 1);
      @(posedge clk); #1;
      flush = 1'b1; req_valid = 4'b1111;
      #1;
      chk("flush_run_ready", req_ready, 4'b0000);
      chk("flush_run_done", flush_done, 1'b0);
      @(posedge clk); #2;
      chk("drain_ready", req_ready, 4'b0000);
      chk("drain_done", flush_done, 1'b0);
      @(posedge clk); #2;
      chk("park_ready", req_ready, 4'b0000);
      chk("flush_done_pulse", flush_done, 1'b1);
`ifdef ADDSUB_ARB_STATS_EN
      chk("issue_cnt", issue_cnt, 32'd12);
      chk("busy_cnt", busy_cnt, 32'd12);
`endif
      @(posedge clk); #2;
      chk("flush_done_end", flush_done, 1'b0);
      chk("park_ready2", req_ready, 4'b0000);
`ifdef ADDSUB_ARB_STATS_EN
      chk("issue_cnt_frozen", issue_cnt, 32'd12);
      chk("busy_cnt_frozen", busy_cnt, 32'd12);
`endif
      flush = 1'b0;
      req_valid = 4'b0000;
      cyc_check(4'b0001, 4'b0001, 1);
      cyc_check(4'b0000, 4'b0000, 0);
      cyc_check(4'b0000, 4'b0000, 0);

      // reset while two ops are in flight: both silently dropped
      cyc_check(4'b0011, 4'b0010, 0);
      @(posedge clk); #1;
      #1;
      chk("pre_rst_ready", req_ready, 4'b0001);
      rst_n = 1'b0;
      #1;
      chk("async_rst_ready", req_ready, 4'b0000);
      chk("async_rst_op_a", op_a, 64'd0);
      chk("async_rst_rsp_valid", rsp_valid, 1'b0);
      chk("async_rst_rsp_sum", rsp_sum, 64'd0);
      req_valid = 4'b0000;
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      cyc_check(4'b0000, 4'b0000, 0);
      cyc_check(4'b0000, 4'b0000, 0);
      cyc_check(4'b0000, 4'b0000, 0);
      set_slice(2, 64'h1234, 64'h1, 1'b1, 64'h1233, 1'b0);
      cyc_check(4'b0100, 4'b0100, 1);
      cyc_check(4'b0000, 4'b0000, 0);

      for (int w = 0; w < 20 && q.size() != 0; w++) @(posedge clk);
      repeat (3) @(posedge clk);
      chk("rsp_queue_drained", q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
